// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Lock-related state is only used when DMEM_ARB_LOCK_EN is defined.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 8;
  localparam int CORE_BURST_DEF = 4;
  localparam int FAIR_W         = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus (one per port) and the single-port memory bus.
// "master" is the side that initiates the access.
interface dmem_req_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, we, re, wdata, input rdata);
  modport slave  (input addr, we, re, wdata, output rdata);
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: core first, debug when the fairness
// counter has reached CORE_BURST, debug only while locked.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int CORE_BURST = CORE_BURST_DEF
) (
  input  logic              en,
  input  logic              c_req,
  input  logic              d_req,
  input  logic [FAIR_W-1:0] fair_cnt,
  input  state_e            state,
  output logic              c_win,
  output logic              d_win
);

  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (en) begin
      if (state == ST_LOCKED) begin
        d_win = d_req;
      end else if (c_req && d_req) begin
        if (fair_cnt == FAIR_W'(CORE_BURST)) d_win = 1'b1;
        else                                 c_win = 1'b1;
      end else begin
        c_win = c_req;
        d_win = d_req;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between core (priority) and debug loader.
// Define DMEM_ARB_LOCK_EN to add the d_lock port and the LOCKED state.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CORE_BURST = CORE_BURST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  dmem_req_if.slave  c_port,
  dmem_req_if.slave  d_port,
`ifdef DMEM_ARB_LOCK_EN
  input  logic       d_lock,
`endif
  dmem_mem_if.master mem,
  output logic       busy
);

  logic              c_win;
  logic              d_win;
  logic              locked_eff;
  state_e            pick_state;
  logic [FAIR_W-1:0] fair_cnt_q, fair_cnt_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              mux_we;

`ifdef DMEM_ARB_LOCK_EN
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_ARB;
    else        state_q <= state_d;
  end

  // Dropping d_lock releases the lock in the same cycle, so that cycle arbitrates normally.
  assign locked_eff = (state_q == ST_LOCKED) && d_lock;

  always_comb begin
    state_d = ST_ARB;
    if (locked_eff || (d_lock && d_win)) state_d = ST_LOCKED;
  end
`else
  assign locked_eff = 1'b0;
`endif

  assign pick_state = locked_eff ? ST_LOCKED : ST_ARB;

  dmem_arb_pick #(.CORE_BURST(CORE_BURST)) u_pick (
    .en       (reset),
    .c_req    (c_port.req),
    .d_req    (d_port.req),
    .fair_cnt (fair_cnt_q),
    .state    (pick_state),
    .c_win    (c_win),
    .d_win    (d_win)
  );

  // c_win with d_req set means core won a contended cycle.
  always_comb begin
    fair_cnt_d = '0;
    if (locked_eff) begin
      fair_cnt_d = fair_cnt_q;
    end else if (c_win && d_port.req) begin
      fair_cnt_d = (fair_cnt_q == FAIR_W'(CORE_BURST)) ? fair_cnt_q : fair_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (c_win && !c_port.we)      rd_owner_d = OWN_CORE;
    else if (d_win && !d_port.we) rd_owner_d = OWN_DBG;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fair_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      fair_cnt_q <= fair_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    mux_addr  = '0;
    mux_wdata = '0;
    mux_we    = 1'b0;
    if (c_win) begin
      mux_addr  = c_port.addr;
      mux_wdata = c_port.wdata;
      mux_we    = c_port.we;
    end else if (d_win) begin
      mux_addr  = d_port.addr;
      mux_wdata = d_port.wdata;
      mux_we    = d_port.we;
    end
  end

  assign mem.addr  = mux_addr;
  assign mem.wdata = mux_wdata;
  assign mem.we    = mux_we;
  assign mem.re    = (c_win || d_win) && !mux_we;

  assign c_port.gnt    = c_win;
  assign d_port.gnt    = d_win;
  // Returns are gated by reset so a read granted just before reset never completes.
  assign c_port.rvalid = reset && (rd_owner_q == OWN_CORE);
  assign d_port.rvalid = reset && (rd_owner_q == OWN_DBG);
  assign c_port.rdata  = c_port.rvalid ? mem.rdata : '0;
  assign d_port.rdata  = d_port.rvalid ? mem.rdata : '0;
  assign busy          = reset && ((rd_owner_q != OWN_NONE) || locked_eff);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a rule-level reference model,
// a behavioural data memory and a few literal directed checks.
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
`ifdef DMEM_ARB_LOCK_EN
  logic d_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) c_if ();
  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
  dmem_mem_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CORE_BURST(CB)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_port (c_if),
    .d_port (d_if),
`ifdef DMEM_ARB_LOCK_EN
    .d_lock (d_lock),
`endif
    .mem    (m_if),
    .busy   (busy)
  );

  // Data memory: write on we, registered read on re.
  logic [DW-1:0] mem_arr [2**AW];
  logic [DW-1:0] mem_rd_q = '0;
  always @(posedge clk) begin
    if (m_if.we) mem_arr[m_if.addr] <= m_if.wdata;
    if (m_if.re) mem_rd_q <= mem_arr[m_if.addr];
  end
  assign m_if.rdata = mem_rd_q;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 5) ? 8'hA7 : DW'(i * 37 + 11);
  endfunction

  // Reference model state
  logic [DW-1:0] ref_mem [2**AW];
  int            streak = 0;
  bit            pv = 1'b0;
  bit            pcore = 1'b0;
  logic [DW-1:0] pdata = '0;
  bit            locked = 1'b0;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem_arr[i] <= init_val(i);
      ref_mem[i] = init_val(i);
    end
  end

  always @(negedge clk) begin
    bit            lk, wc, wd, ewe, ere;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    if (!reset) begin
      chk("rst_c_gnt", c_if.gnt, 0);
      chk("rst_d_gnt", d_if.gnt, 0);
      chk("rst_mem_we", m_if.we, 0);
      chk("rst_mem_re", m_if.re, 0);
      chk("rst_mem_addr", m_if.addr, 0);
      chk("rst_mem_wdata", m_if.wdata, 0);
      chk("rst_c_rvalid", c_if.rvalid, 0);
      chk("rst_d_rvalid", d_if.rvalid, 0);
      chk("rst_c_rdata", c_if.rdata, 0);
      chk("rst_d_rdata", d_if.rdata, 0);
      chk("rst_busy", busy, 0);
      streak = 0;
      pv     = 1'b0;
      locked = 1'b0;
    end else begin
      lk = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lk = locked && d_lock;
`endif
      wc = 1'b0;
      wd = 1'b0;
      if (lk) begin
        wd = d_if.req;
      end else if (c_if.req && d_if.req) begin
        wd = (streak == CB);
        wc = !wd;
      end else begin
        wc = c_if.req;
        wd = d_if.req;
      end
      ewe = wc ? c_if.we : (wd ? d_if.we : 1'b0);
      ere = (wc || wd) && !ewe;
      ea  = wc ? c_if.addr  : (wd ? d_if.addr  : '0);
      ew  = wc ? c_if.wdata : (wd ? d_if.wdata : '0);

      chk("c_gnt", c_if.gnt, wc);
      chk("d_gnt", d_if.gnt, wd);
      chk("mem_we", m_if.we, ewe);
      chk("mem_re", m_if.re, ere);
      chk("mem_addr", m_if.addr, ea);
      chk("mem_wdata", m_if.wdata, ew);
      chk("c_rvalid", c_if.rvalid, pv && pcore);
      chk("d_rvalid", d_if.rvalid, pv && !pcore);
      chk("c_rdata", c_if.rdata, (pv && pcore) ? pdata : '0);
      chk("d_rdata", d_if.rdata, (pv && !pcore) ? pdata : '0);
      chk("busy", busy, pv || lk);

      if (!lk) streak = (wc && d_if.req) ? streak + 1 : 0;
      pv    = ere;
      pcore = wc;
      pdata = ref_mem[ea];
      if (ewe) ref_mem[ea] = ew;
`ifdef DMEM_ARB_LOCK_EN
      locked = lk || (d_lock && wd);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(bit req, bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata);
    c_if.req = req; c_if.we = we; c_if.addr = addr; c_if.wdata = wdata;
  endtask

  task automatic set_d(bit req, bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata);
    d_if.req = req; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata;
  endtask

  task automatic idle();
    set_c(0, 0, '0, '0);
    set_d(0, 0, '0, '0);
  endtask

  task automatic contend();
    set_c(1, 0, AW'($urandom_range(0, 31)), DW'($urandom));
    set_d(1, 0, AW'($urandom_range(0, 31)), DW'($urandom));
  endtask

  bit cg_prev = 1'b0;
  bit dg_prev = 1'b0;

  initial begin
    idle();
    // Requests during reset must not be granted
    for (int i = 0; i < 3; i++) begin
      tick();
      set_c(1, 1'($urandom), AW'($urandom), DW'($urandom));
      set_d(1, 1'($urandom), AW'($urandom), DW'($urandom));
    end

    // Core-only read on the first cycle out of reset
    tick(); reset = 1'b1; set_c(1, 0, 5, 0); set_d(0, 0, 0, 0);
    #2 chk("t1_c_gnt", c_if.gnt, 1);
    tick(); idle();
    #2 chk("t1_c_rvalid", c_if.rvalid, 1);
    chk("t1_c_rdata", c_if.rdata, 8'hA7);

    // Contention: C,C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      tick(); contend();
      #2 chk($sformatf("t2_c_gnt_%0d", i), c_if.gnt, (i % 5) != 4);
      chk($sformatf("t2_d_gnt_%0d", i), d_if.gnt, (i % 5) == 4);
    end

    // Core write then debug read of the same address
    tick(); set_c(1, 1, 2, 8'h3C); set_d(0, 0, 0, 0);
    tick(); set_c(0, 0, 0, 0); set_d(1, 0, 2, 0);
    tick(); idle();
    #2 chk("t3_d_rvalid", d_if.rvalid, 1);
    chk("t3_d_rdata", d_if.rdata, 8'h3C);
    chk("t3_c_rvalid", c_if.rvalid, 0);

    // Reset right after a core read grant, fairness must restart
    for (int i = 0; i < 3; i++) begin tick(); contend(); end
    tick(); reset = 1'b0;
    #2 chk("t4_c_rvalid", c_if.rvalid, 0);
    chk("t4_busy", busy, 0);
    tick(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      contend();
      #2 chk($sformatf("t4_c_gnt_%0d", i), c_if.gnt, i != 4);
    end

    // Idle clears fairness
    for (int i = 0; i < 3; i++) begin tick(); contend(); end
    tick(); idle();
    tick();
    #2 chk("t6_mem_we", m_if.we, 0);
    chk("t6_mem_re", m_if.re, 0);
    chk("t6_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); contend();
      #2 chk($sformatf("t6_c_gnt_%0d", i), c_if.gnt, i != 4);
    end

`ifdef DMEM_ARB_LOCK_EN
    tick(); idle();
    tick(); set_d(1, 0, 3, 0); d_lock = 1'b1;
    #2 chk("t5_d_gnt", d_if.gnt, 1);
    for (int i = 0; i < 6; i++) begin
      tick(); set_c(1, 0, 1, 0); set_d(1'($urandom), 0, 4, 0);
      #2 chk($sformatf("t5_c_gnt_%0d", i), c_if.gnt, 0);
      chk($sformatf("t5_busy_%0d", i), busy, 1);
    end
    tick(); d_lock = 1'b0; set_d(0, 0, 0, 0); set_c(1, 0, 1, 0);
    #2 chk("t5_release_c_gnt", c_if.gnt, 1);
`endif

    // Randomized traffic; requests hold their fields until granted
    tick(); idle();
    #2 cg_prev = 1'b0; dg_prev = 1'b0;
    for (int n = 0; n < 800; n++) begin
      tick();
      reset = ($urandom_range(0, 63) != 0);
      if (!c_if.req || cg_prev)
        set_c($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      if (!d_if.req || dg_prev)
        set_d($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
`ifdef DMEM_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
`endif
      #2 cg_prev = c_if.gnt; dg_prev = d_if.gnt;
    end

    tick(); reset = 1'b1; idle();
`ifdef DMEM_ARB_LOCK_EN
    d_lock = 1'b0;
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
